cpu_io_port: RTL
================

# cpu_io_port

Parametrised multi-channel I/O port for the simple CPU, the next generation of its single 16-bit `input_pin`/`output_pin`/`input_enable` interface. Each channel captures a word from its input pins on a rising edge of its `input_enable` into a per-channel FIFO, and drives a CPU-written output register onto its output pins. The CPU reaches both sides through a small synchronous read/write bus with status flags and an interrupt. The block sits between the CPU core and the chip-level pins inside `top`.

## Interface
- `WIDTH`, 16: data width per channel.
- `CHANNELS`, 2: number of channels, ≥1.
- `DEPTH`, 4: input FIFO entries per channel, power of two, ≥2.
- `OUT_RESET`, 16'h0000: reset value of every output register.
- `SEL_W`, max(1, clog2(CHANNELS)): channel select width (localparam).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `input_pin`  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
- `input_enable`  in  CHANNELS  per-channel capture strobe (level, edge-detected).
- `output_pin`  out  CHANNELS*WIDTH  output registers, same packing.
- `cpu_sel`  in  SEL_W  channel addressed by rd/wr/clr.
- `cpu_rd`  in  1  pop one word from FIFO `cpu_sel`.
- `cpu_wr`  in  1  write `cpu_wdata` to output register `cpu_sel`.
- `cpu_clr`  in  1  clear overflow flag of `cpu_sel`.
- `cpu_wdata`  in  WIDTH  write data.
- `cpu_rdata`  out  WIDTH  read data.
- `cpu_rvalid`  out  1  one-cycle pulse, `cpu_rdata` valid.
- `in_empty`  out  CHANNELS  FIFO c empty.
- `in_full`  out  CHANNELS  FIFO c holds DEPTH words.
- `overflow`  out  CHANNELS  sticky, word dropped on full FIFO c.
- `irq`  out  1  OR over channels of (~in_empty | overflow).

## Operation
- Reset (async on `reset`=0): `output_pin` = OUT_RESET per channel; FIFO pointers/counts 0 (`in_empty`=all 1, `in_full`=0); `overflow`=0; `cpu_rdata`=0; `cpu_rvalid`=0; `irq`=0; enable history register = all 1.
- Capture: push_c = `input_enable[c]` & ~en_q[c]; en_q[c] <= `input_enable[c]` every cycle. On push_c, the `input_pin` slice sampled at that same edge is written to FIFO c.
- Enable held high across reset release: no capture until it falls and rises again.
- Push to full FIFO with no pop on that channel: word dropped, `overflow[c]` set; contents unchanged.
- Read: `cpu_rd`, `cpu_sel`=c < CHANNELS, FIFO non-empty → head word registered to `cpu_rdata`, pointer advances. Empty FIFO or `cpu_sel` ≥ CHANNELS → `cpu_rdata`=0, no state change. `cpu_rvalid` pulses in all cases.
- `cpu_rdata` holds its last value when `cpu_rvalid`=0.
- Write: `cpu_wr`, `cpu_sel` < CHANNELS → output register updated; out-of-range select ignored.
- Same-channel push and pop in one cycle: both happen, count unchanged. On empty: read returns 0 (no bypass), pushed word stored, count becomes 1. On full: pop frees a slot, push accepted, no overflow.
- `cpu_rd`, `cpu_wr` and `cpu_clr` may be asserted together; all act.
- `cpu_clr` same cycle as a new overflow event on that channel: set wins.
- Pointers are log2(DEPTH) bits wrapping modulo DEPTH; count is log2(DEPTH)+1 bits.

## Timing
- Capture: rising enable sampled at edge k → word in FIFO and `in_empty[c]`=0 after edge k.
- Read latency: 1 cycle. `cpu_rd` at edge k → `cpu_rvalid`=1, `cpu_rdata` valid after edge k, for exactly one cycle. Back-to-back reads give one word per cycle.
- Write latency: 1 cycle. `cpu_wr` at edge k → `output_pin` changes after edge k.
- `in_empty`, `in_full`, `overflow` are registered and update after the edge that changes them. `irq` is combinational from these registers.
- Channels are independent; a capture on one channel never stalls another.

## Test plan
- Reset mid-operation: fill FIFO 0 with 3 words, write 16'h1234 to output 0, pull `reset` low between edges → immediately `output_pin`=OUT_RESET, `in_empty`=all 1, `irq`=0, no `cpu_rvalid`.
- Capture/read order: pulse `input_enable[1]` with `input_pin` ch1 = 16'hF0F0, then 16'h0F0F; hold enable high 10 cycles on the second → exactly 2 words. Two reads on sel=1 return F0F0 then 0F0F, each one cycle after `cpu_rd`; `in_empty[1]` set after the second read.
- Overflow: 5 enable pulses on ch0 (DEPTH=4), values 1..5 → `in_full[0]`=1, `overflow[0]`=1, reads return 1,2,3,4. `cpu_clr` sel=0 clears it; `cpu_clr` with a simultaneous dropped push leaves it set.
- Simultaneous push/pop: on full FIFO, push + read in one cycle → no overflow, count stays 4. On empty, push 16'hAAAA + read → rdata 0, then next read returns AAAA.
- Enable held through reset: `input_enable[0]`=1 before and after reset release → no capture; after a fall and rise, one capture.
- Output/range: `cpu_wr` sel=1 data 16'hBEEF → only ch1 pins show BEEF next cycle. With CHANNELS=3, `cpu_sel`=3 write ignored, read gives rvalid with rdata 0.

Source files
------------

// File: rtl/cpu_io_port.sv
// cpu_io_port: multi-channel CPU I/O port. Each channel captures a word
// from its input pins into a small FIFO on a rising input_enable. It also
// drives a CPU-written output register onto its output pins. The CPU
// pops words, writes outputs and clears overflow over a simple
// single-cycle bus.
module cpu_io_port #(
    parameter int               WIDTH     = 16,
    parameter int               CHANNELS  = 2,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    localparam int              SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] input_pin,
    input  logic [CHANNELS-1:0]       input_enable,
    output logic [CHANNELS*WIDTH-1:0] output_pin,
    input  logic [SEL_W-1:0]          cpu_sel,
    input  logic                      cpu_rd,
    input  logic                      cpu_wr,
    input  logic                      cpu_clr,
    input  logic [WIDTH-1:0]          cpu_wdata,
    output logic [WIDTH-1:0]          cpu_rdata,
    output logic                      cpu_rvalid,
    output logic [CHANNELS-1:0]       in_empty,
    output logic [CHANNELS-1:0]       in_full,
    output logic [CHANNELS-1:0]       overflow,
    output logic                      irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // A select beyond the last channel addresses nothing at all.
    logic sel_ok;
    assign sel_ok = ({1'b0, cpu_sel} < (SEL_W + 1)'(CHANNELS));

    logic [CHANNELS-1:0] pop;
    logic [WIDTH-1:0]    head_word [CHANNELS];
    logic [WIDTH-1:0]    rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] mem [DEPTH];
            logic [PTR_W-1:0] wr_ptr;
            logic [PTR_W-1:0] rd_ptr;
            logic [CNT_W-1:0] cnt;
            logic             en_q;
            logic             ovf_q;
            logic [WIDTH-1:0] out_q;
            logic             hit;
            logic             push;
            logic             full;
            logic             accept;
            logic             drop;

            assign hit    = sel_ok && (cpu_sel == SEL_W'(gi));
            assign push   = input_enable[gi] & ~en_q;
            assign full   = (cnt == CNT_W'(DEPTH));
            assign pop[gi] = cpu_rd & hit & (cnt != '0);
            // A simultaneous pop frees the slot the push needs.
            assign accept = push & (~full | pop[gi]);
            assign drop   = push & full & ~pop[gi];

            // FIFO storage: plain array without reset so it maps to RAM.
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[wr_ptr] <= input_pin[gi*WIDTH +: WIDTH];
                end
            end

            assign head_word[gi] = mem[rd_ptr];

            // Pointers, occupancy, overflow flag, enable history and output register.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                    en_q   <= 1'b1;
                    ovf_q  <= 1'b0;
                    out_q  <= OUT_RESET;
                end else begin
                    en_q <= input_enable[gi];
                    if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (accept && !pop[gi]) begin
                        cnt <= cnt + 1'b1;
                    end else if (!accept && pop[gi]) begin
                        cnt <= cnt - 1'b1;
                    end
                    // A new drop outranks a clear in the same cycle.
                    if (drop) begin
                        ovf_q <= 1'b1;
                    end else if (cpu_clr && hit) begin
                        ovf_q <= 1'b0;
                    end
                    if (cpu_wr && hit) begin
                        out_q <= cpu_wdata;
                    end
                end
            end

            assign in_empty[gi]                  = (cnt == '0);
            assign in_full[gi]                   = full;
            assign overflow[gi]                  = ovf_q;
            assign output_pin[gi*WIDTH +: WIDTH] = out_q;
        end
    endgenerate

    // Head word of the channel being popped; zero for empty or invalid reads.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (pop[c]) begin
                rd_word = head_word[c];
            end
        end
    end

    // Read response register: one-cycle valid pulse, data held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_rd;
            if (cpu_rd) begin
                cpu_rdata <= rd_word;
            end
        end
    end

    assign irq = |(~in_empty | overflow);

endmodule
